// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with private HI/LO registers; 33-cycle fixed latency.
// Define MULDIV_MADD_EN to enable MADD/MADDU (accumulate product into HI/LO).
module mips_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMadd  = 3'b100;
    localparam logic [2:0] OpMaddu = 3'b101;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, a_q, hi_q, lo_q;
    logic             sign_a_q, sign_b_q, is_signed_q, is_div_q, is_madd_q;
    logic             busy_q, done_q, dbz_q;

    // Launch decode
    logic             op_valid, op_signed, op_div, op_madd;
    logic [WIDTH-1:0] a_abs, b_abs;

    always_comb begin
        op_signed = (op == OpMult) || (op == OpDiv) || (op == OpMadd);
        op_div    = (op == OpDiv) || (op == OpDivu);
        op_madd   = (op == OpMadd) || (op == OpMaddu);
`ifdef MULDIV_MADD_EN
        op_valid  = (op <= OpMaddu);
`else
        op_valid  = (op <= OpDivu) && (op != OpMultu || op == OpMultu);
`endif
        a_abs     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_abs     = (op_signed && b[WIDTH-1]) ? -b : b;
    end

    // One iteration of shift-add multiply or restoring divide
    logic [WIDTH:0]       mul_sum, mul_add, div_shift;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH-1:0]     div_diff, div_rem_next, div_quo_next;
    logic                 div_ge;

    always_comb begin
        mul_sum      = {1'b0, acc_hi_q} + {1'b0, opnd_q};
        mul_add      = acc_lo_q[0] ? mul_sum : {1'b0, acc_hi_q};
        mul_next     = {mul_add, acc_lo_q[WIDTH-1:1]};
        div_shift    = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge       = (div_shift >= {1'b0, opnd_q});
        // When div_ge holds the true difference is below the divisor, so W bits suffice.
        div_diff     = div_shift[WIDTH-1:0] - opnd_q;
        div_rem_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_quo_next = {acc_lo_q[WIDTH-2:0], div_ge};
    end

    // Sign fixup and result selection for the FIX state
    logic [2*WIDTH-1:0] prod, prod_fix, madd_sum;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;
    logic               div_zero;

    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -prod : prod;
        quo_fix  = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -acc_lo_q : acc_lo_q;
        rem_fix  = (is_signed_q && sign_a_q) ? -acc_hi_q : acc_hi_q;
        div_zero = is_div_q && (opnd_q == '0);
`ifdef MULDIV_MADD_EN
        madd_sum = {hi_q, lo_q} + prod_fix;
`else
        madd_sum = prod_fix;
`endif
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end else if (is_madd_q) begin
            res_hi = madd_sum[2*WIDTH-1:WIDTH];
            res_lo = madd_sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            a_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            is_signed_q <= 1'b0;
            is_div_q    <= 1'b0;
            is_madd_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && op_valid) begin
                        state_q     <= StCalc;
                        busy_q      <= 1'b1;
                        dbz_q       <= 1'b0;
                        cnt_q       <= '0;
                        acc_hi_q    <= '0;
                        // Divide: acc_lo holds dividend, opnd divisor. Multiply: the reverse.
                        acc_lo_q    <= op_div ? a_abs : b_abs;
                        opnd_q      <= op_div ? b_abs : a_abs;
                        a_q         <= a;
                        sign_a_q    <= a[WIDTH-1];
                        sign_b_q    <= b[WIDTH-1];
                        is_signed_q <= op_signed;
                        is_div_q    <= op_div;
                        is_madd_q   <= op_madd;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                StCalc: begin
                    if (is_div_q) begin
                        acc_hi_q <= div_rem_next;
                        acc_lo_q <= div_quo_next;
                    end else begin
                        acc_hi_q <= mul_next[2*WIDTH-1:WIDTH];
                        acc_lo_q <= mul_next[WIDTH-1:0];
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    dbz_q   <= div_zero;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
